// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: serially loads a pattern into a chain of scan cells,
// pulses one functional capture cycle, then unloads the captured response.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 4,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic                 scan_out,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 resp_valid,
    output logic [CHAIN_LEN-1:0] response
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT_IN  = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_SHIFT_OUT = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [CHAIN_LEN-1:0] pat_r;
    logic [CHAIN_LEN-1:0] cap_r;
    logic [CHAIN_LEN-1:0] cap_next_s;
    logic                 cnt_last_s;

    // Unload order is tail first: shift-out step k fills bit CHAIN_LEN-1-k.
    function automatic logic [CHAIN_LEN-1:0] place_bit(
        input logic [CHAIN_LEN-1:0] vec,
        input logic [CNT_W-1:0]     step,
        input logic                 bit_val
    );
        logic [CHAIN_LEN-1:0] res;
        res = vec;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            if (step == CNT_W'(CHAIN_LEN - 1 - i)) begin
                res[i] = bit_val;
            end else begin
                res[i] = vec[i];
            end
        end
        return res;
    endfunction

    // Phase-end detection and next value of the unload register.
    always_comb begin
        cnt_last_s = (cnt_r == CNT_LAST);
        cap_next_s = place_bit(cap_r, cnt_r, scan_out);
    end

    // Sequencer: state, counter, pattern shifter and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            pat_r      <= '0;
            cap_r      <= '0;
            scan_en    <= 1'b0;
            scan_in    <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            response   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    resp_valid <= 1'b0;
                    cnt_r      <= CNT_ZERO;
                    if (start) begin
                        // MSB goes out first; pat_r keeps the remaining bits MSB-aligned.
                        pat_r   <= pattern_in << 1'b1;
                        scan_in <= pattern_in[CHAIN_LEN-1];
                        scan_en <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= ST_SHIFT_IN;
                    end else begin
                        scan_en <= 1'b0;
                        scan_in <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                ST_SHIFT_IN: begin
                    if (cnt_last_s) begin
                        cnt_r   <= CNT_ZERO;
                        scan_en <= 1'b0;
                        scan_in <= 1'b0;
                        state_r <= ST_CAPTURE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        scan_in <= pat_r[CHAIN_LEN-1];
                        pat_r   <= pat_r << 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    cnt_r   <= CNT_ZERO;
                    scan_en <= 1'b1;
                    scan_in <= 1'b0;
                    state_r <= ST_SHIFT_OUT;
                end
                ST_SHIFT_OUT: begin
                    cap_r <= cap_next_s;
                    if (cnt_last_s) begin
                        cnt_r      <= CNT_ZERO;
                        response   <= cap_next_s;
                        resp_valid <= 1'b1;
                        state_r    <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    cnt_r      <= CNT_ZERO;
                    busy       <= 1'b0;
                    resp_valid <= 1'b0;
                    scan_en    <= 1'b0;
                    scan_in    <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= CNT_ZERO;
                    scan_en    <= 1'b0;
                    scan_in    <= 1'b0;
                    busy       <= 1'b0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Scoreboard bench for scan_chain_ctrl: a 4-cell and a 1-cell instance, each
// driving a behavioural scan chain whose capture function is q ^ mask.
module tb_scan_chain_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start4, start1;
    logic [3:0] pat4;
    logic [0:0] pat1;
    logic [3:0] mask4;
    logic [0:0] mask1;

    logic       se4, si4, busy4, rv4, so4;
    logic [3:0] resp4;
    logic       se1, si1, busy1, rv1, so1;
    logic [0:0] resp1;

    logic [3:0] q4 = 4'b0000;
    logic       q1 = 1'b0;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] pat;
        logic [3:0] exp;
        int         s;
    } sb_t;

    sb_t        sbq0[$];
    sb_t        sbq1[$];
    logic [3:0] last_resp0, last_resp1;

    scan_chain_ctrl #(.CHAIN_LEN(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .pattern_in(pat4),
        .scan_out(so4), .scan_en(se4), .scan_in(si4), .busy(busy4),
        .resp_valid(rv4), .response(resp4)
    );

    scan_chain_ctrl #(.CHAIN_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .pattern_in(pat1),
        .scan_out(so1), .scan_en(se1), .scan_in(si1), .busy(busy1),
        .resp_valid(rv1), .response(resp1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // scan chains: shift toward the tail when se=1, else capture d = q ^ mask
    always @(posedge clk) begin
        if (se4) q4 <= {q4[2:0], si4};
        else     q4 <= q4 ^ mask4;
    end
    always @(posedge clk) begin
        if (se1) q1 <= si1;
        else     q1 <= q1 ^ mask1[0];
    end
    assign so4 = q4[3];
    assign so1 = q1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected per-cycle behaviour relative to the accepting edge (r=1 is the
    // first cycle after it): shift in for L cycles, capture, shift out for L, done.
    task automatic check_inst(input int inst, input int L, input logic b, input logic se,
                              input logic si, input logic rv, input logic [3:0] resp);
        sb_t        e;
        bit         have;
        int         r;
        logic [3:0] lr;
        logic       eb, ese, esi, erv;
        logic [3:0] eresp;
        if (inst == 0) begin
            have = (sbq0.size() > 0);
            if (have) e = sbq0[0];
            lr = last_resp0;
        end else begin
            have = (sbq1.size() > 0);
            if (have) e = sbq1[0];
            lr = last_resp1;
        end
        eb = 1'b0; ese = 1'b0; esi = 1'b0; erv = 1'b0; eresp = lr;
        if (reset == 1'b0) begin
            eresp = 4'b0000;
        end else begin
            r = have ? (cyc - e.s + 1) : 0;
            if (have && r >= 1) begin
                eb  = 1'b1;
                ese = (r != L + 1);
                if (r <= L) esi = e.pat[L - r];
                erv = (r == 2 * L + 2);
                if (erv) begin
                    eresp = e.exp;
                    if (inst == 0) begin
                        void'(sbq0.pop_front());
                        last_resp0 = e.exp;
                    end else begin
                        void'(sbq1.pop_front());
                        last_resp1 = e.exp;
                    end
                end
            end
        end
        chk($sformatf("busy%0d", inst), {31'b0, b}, {31'b0, eb});
        chk($sformatf("scan_en%0d", inst), {31'b0, se}, {31'b0, ese});
        chk($sformatf("scan_in%0d", inst), {31'b0, si}, {31'b0, esi});
        chk($sformatf("resp_valid%0d", inst), {31'b0, rv}, {31'b0, erv});
        chk($sformatf("response%0d", inst), {28'b0, resp}, {28'b0, eresp});
    endtask

    // monitor: compare every output of both instances once per cycle
    always @(negedge clk) begin
        check_inst(0, 4, busy4, se4, si4, rv4, resp4);
        check_inst(1, 1, busy1, se1, si1, rv1, {3'b000, resp1});
    end

    task automatic run_test(input int inst, input logic [3:0] pat, input logic [3:0] msk,
                            input int noise_r, input int gap);
        int  L;
        sb_t e;
        bit  noise;
        L = (inst == 0) ? 4 : 1;
        @(negedge clk);
        start4 = 1'b0;
        start1 = 1'b0;
        e.s = cyc + 1;
        if (inst == 0) begin
            e.pat = pat;
            e.exp = pat ^ msk;
            mask4 = msk;
            pat4  = pat;
            start4 = 1'b1;
            sbq0.push_back(e);
        end else begin
            e.pat = {3'b000, pat[0]};
            e.exp = {3'b000, pat[0] ^ msk[0]};
            mask1 = msk[0:0];
            pat1  = pat[0:0];
            start1 = 1'b1;
            sbq1.push_back(e);
        end
        for (int r = 1; r <= 2 * L + 2; r++) begin
            @(negedge clk);
            noise = (r == noise_r) || ($urandom_range(0, 3) == 0);
            if (inst == 0) begin
                start4 = noise;
                pat4   = (r == noise_r) ? 4'b1111 : 4'($urandom);
            end else begin
                start1 = noise;
                pat1   = 1'($urandom);
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            start4 = 1'b0;
            start1 = 1'b0;
        end
    endtask

    initial begin
        sb_t e;
        reset  = 1'b0;
        start4 = 1'b0; start1 = 1'b0;
        pat4   = 4'b0000; pat1 = 1'b0;
        mask4  = 4'b0000; mask1 = 1'b0;
        last_resp0 = 4'b0000;
        last_resp1 = 4'b0000;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;

        run_test(0, 4'b1011, 4'b0000, 0, 1);
        run_test(0, 4'b0110, 4'b1111, 0, 2);
        run_test(0, 4'b1000, 4'($urandom), 0, 0);
        run_test(0, 4'b1010, 4'b0000, 7, 1);

        // abort a test during shift-in with an asynchronous reset
        @(negedge clk);
        start4 = 1'b0; start1 = 1'b0;
        e.pat = 4'b1100; e.exp = 4'b1100; e.s = cyc + 1;
        mask4 = 4'b0000; pat4 = 4'b1100; start4 = 1'b1;
        sbq0.push_back(e);
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy4}, 32'd0);
        chk("rst_scan_en", {31'b0, se4}, 32'd0);
        chk("rst_scan_in", {31'b0, si4}, 32'd0);
        chk("rst_resp_valid", {31'b0, rv4}, 32'd0);
        chk("rst_response", {28'b0, resp4}, 32'd0);
        sbq0.delete();
        sbq1.delete();
        last_resp0 = 4'b0000;
        last_resp1 = 4'b0000;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;

        run_test(0, 4'b0101, 4'b0000, 0, 1);
        run_test(1, 4'b0001, 4'b0001, 0, 1);

        for (int i = 0; i < 30; i++)
            run_test(0, 4'($urandom), 4'($urandom), $urandom_range(1, 10), $urandom_range(0, 2));
        for (int i = 0; i < 10; i++)
            run_test(1, 4'($urandom), 4'($urandom), $urandom_range(1, 4), $urandom_range(0, 2));

        @(negedge clk);
        start4 = 1'b0; start1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("sb_drain4", sbq0.size(), 32'd0);
        chk("sb_drain1", sbq1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
